// File: rtl/pocket_spi_pkg.sv
// Shared types and elaboration helpers for the Pocket bridge SPI shifter.
// The optional receive path is selected with the POCKET_SPI_RX_EN macro in pocket_spi_shifter.
package pocket_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LO,
        ST_HI,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic int calcSteps(input int dw, input int lanes);
        return dw / lanes;
    endfunction

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit lanesLegal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

endpackage

// File: rtl/pocket_spi_fifo.sv
// Synchronous FIFO holding {last, word} entries for the SPI shifter.
// Pointers carry one wrap bit so full and empty are distinguishable.
module pocket_spi_fifo
    import pocket_spi_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = cntWidth(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty_o = (wrPtr_q == rdPtr_q);
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/pocket_spi_shifter.sv
// Multi-lane SPI word shifter with chip-select framing, LSB first.
// Define POCKET_SPI_RX_EN to build the receive deserialiser (rx_data/rx_valid).
module pocket_spi_shifter
    import pocket_spi_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic             sclk,
    output logic             ss_n,
    output logic [LANES-1:0] dout,
    output logic             dout_oe,
    input  logic [LANES-1:0] sin,
    output logic [DW-1:0]    rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int STEPS    = calcSteps(DW, LANES);
    localparam int CW       = cntWidth(STEPS);
    localparam int GW       = cntWidth(GAP);
    localparam bit LANES_OK = lanesLegal(LANES) && ((DW % LANES) == 0);

    if (!LANES_OK) begin : gBadConfig
        $error("pocket_spi_shifter: LANES must be 1, 2 or 4 and divide DW");
    end

    state_e          state_q, state_d;
    logic [DW-1:0]   sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gapCnt_q, gapCnt_d;
    logic            last_q, last_d;
    logic            fifoPop;
    logic            fifoFull;
    logic            fifoEmpty;
    logic [DW:0]     fifoData;
    logic            inFrame;

    pocket_spi_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (din_valid),
        .pop_i   (fifoPop),
        .wdata_i ({din_last, din}),
        .rdata_o (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            gapCnt_q <= '0;
            last_q   <= 1'b0;
        end else if (cen) begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            gapCnt_q <= gapCnt_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        gapCnt_d = gapCnt_q;
        last_d   = last_q;
        fifoPop  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (!fifoEmpty) state_d = ST_LOAD;
            ST_LOAD: begin
                fifoPop = cen;
                sr_d    = fifoData[DW-1:0];
                last_d  = fifoData[DW];
                cnt_d   = CW'(STEPS - 1);
                state_d = ST_LO;
            end
            ST_LO:   state_d = ST_HI;
            ST_HI: begin
                if (cnt_q != '0) begin
                    sr_d    = sr_q >> LANES;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = ST_LO;
                end else if (last_q) begin
                    gapCnt_d = GW'((GAP > 0) ? GAP - 1 : 0);
                    state_d  = (GAP > 0) ? ST_GAP : ST_IDLE;
                end else if (!fifoEmpty) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: if (!fifoEmpty) state_d = ST_LOAD;
            ST_GAP: begin
                if (gapCnt_q == '0) state_d = ST_IDLE;
                else                gapCnt_d = gapCnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign inFrame   = (state_q == ST_LOAD) || (state_q == ST_LO) ||
                       (state_q == ST_HI)   || (state_q == ST_HOLD);
    assign ss_n      = !inFrame;
    assign dout_oe   = inFrame;
    assign sclk      = (state_q == ST_HI);
    assign dout      = inFrame ? sr_q[LANES-1:0] : '0;
    assign busy      = (state_q != ST_IDLE) || !fifoEmpty;
    assign din_ready = !fifoFull;

`ifdef POCKET_SPI_RX_EN
    logic [DW-1:0]       rxShift_q;
    logic [DW-1:0]       rxData_q;
    logic                rxValid_q;
    logic [DW+LANES-1:0] rxWide;
    logic [DW-1:0]       rxNext;
    logic                unusedRxLow;

    assign rxWide      = {sin, rxShift_q};
    assign rxNext      = rxWide[DW+LANES-1:LANES];
    assign unusedRxLow = ^rxWide[LANES-1:0];

    // Lanes are sampled on the HI tick; the final step of a word publishes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxShift_q <= '0;
            rxData_q  <= '0;
            rxValid_q <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            if (cen && (state_q == ST_HI)) begin
                rxShift_q <= rxNext;
                if (cnt_q == '0) begin
                    rxData_q  <= rxNext;
                    rxValid_q <= 1'b1;
                end
            end
        end
    end

    assign rx_data  = rxData_q;
    assign rx_valid = rxValid_q;
`else
    logic unusedSin;

    assign unusedSin = ^sin;
    assign rx_data   = '0;
    assign rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pocket_spi_shifter.sv
// Directed bench for pocket_spi_shifter: tick-by-tick frame table plus framing,
// FIFO, HOLD, lane-width and reset sequences. Adapts to the POCKET_SPI_RX_EN build.
module tb_pocket_spi_shifter;

`ifdef POCKET_SPI_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    typedef struct {
        logic       cen;
        logic       ssN;
        logic       sclk;
        logic [1:0] dout;
        logic       oe;
        logic       busy;
        logic       rxValid;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic [7:0] din;
    logic       din_valid, din_last, valid1, valid4;

    logic       din_ready, sclk, ss_n, dout_oe, rx_valid, busy;
    logic [1:0] dout;
    logic [7:0] rx_data;
    logic       ready1, sclk1, ssN1, oe1, rxValid1, busy1;
    logic [0:0] dout1;
    logic [7:0] rxData1;
    logic       ready4, sclk4, ssN4, oe4, rxValid4, busy4;
    logic [3:0] dout4;
    logic [7:0] rxData4;

    int total = 0;
    int bad   = 0;
    vec_t vecs[15];

    always #5 clk = ~clk;

    pocket_spi_shifter #(.DW(8), .LANES(2), .DEPTH(4), .GAP(2)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_ready(din_ready), .sclk(sclk), .ss_n(ss_n),
        .dout(dout), .dout_oe(dout_oe), .sin(dout), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy)
    );

    pocket_spi_shifter #(.DW(8), .LANES(1), .DEPTH(4), .GAP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(din), .din_valid(valid1),
        .din_last(din_last), .din_ready(ready1), .sclk(sclk1), .ss_n(ssN1),
        .dout(dout1), .dout_oe(oe1), .sin(dout1), .rx_data(rxData1),
        .rx_valid(rxValid1), .busy(busy1)
    );

    pocket_spi_shifter #(.DW(8), .LANES(4), .DEPTH(4), .GAP(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(din), .din_valid(valid4),
        .din_last(din_last), .din_ready(ready4), .sclk(sclk4), .ss_n(ssN4),
        .dout(dout4), .dout_oe(oe4), .sin(dout4), .rx_data(rxData4),
        .rx_valid(rxValid4), .busy(busy4)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cenVal);
        cen = cenVal;
        @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [7:0] data, input logic last, input logic cenVal);
        din       = data;
        din_last  = last;
        din_valid = 1'b1;
        applyStimulus(cenVal);
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lowCnt, hiCnt, gapCnt, rxCnt, extra;
        int e2, e1, e4, r2, r1, r4;
        logic [7:0] d2, d1, d4;
        logic p2, p1, p4;
        bit ended;

        // Single 0xB4 frame, one record per cen tick starting at the LOAD edge.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, RX_EN};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; cen = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0;
        valid1 = 1'b0; valid4 = 1'b0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        rst_n = 1'b1;
        checkOutput("reset ss_n", ss_n, 1);
        checkOutput("reset sclk", sclk, 0);
        checkOutput("reset dout", dout, 0);
        checkOutput("reset dout_oe", dout_oe, 0);
        checkOutput("reset rx_data", rx_data, 0);
        checkOutput("reset rx_valid", rx_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset din_ready", din_ready, 1);

        $display("[TB] single word 0xB4 frame");
        pushWord(8'hB4, 1'b1, 1'b1);
        checkOutput("queued busy", busy, 1);
        checkOutput("queued ss_n", ss_n, 1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].cen);
            checkOutput($sformatf("vec%0d ss_n", i), ss_n, vecs[i].ssN);
            checkOutput($sformatf("vec%0d sclk", i), sclk, vecs[i].sclk);
            checkOutput($sformatf("vec%0d dout", i), dout, vecs[i].dout);
            checkOutput($sformatf("vec%0d dout_oe", i), dout_oe, vecs[i].oe);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            checkOutput($sformatf("vec%0d rx_valid", i), rx_valid, vecs[i].rxValid);
        end
        checkOutput("B4 rx_data", rx_data, RX_EN ? 32'hB4 : 32'h0);

        $display("[TB] four-word frame with overflow attempt");
        pushWord(8'hF8, 1'b0, 1'b0);
        pushWord(8'h00, 1'b0, 1'b0);
        pushWord(8'h00, 1'b0, 1'b0);
        checkOutput("ready after 3 pushes", din_ready, 1);
        pushWord(8'h00, 1'b1, 1'b0);
        checkOutput("ready after 4 pushes", din_ready, 0);
        pushWord(8'h77, 1'b1, 1'b0);
        checkOutput("ready after ignored push", din_ready, 0);
        checkOutput("stalled ss_n", ss_n, 1);
        lowCnt = 0; hiCnt = 0; rxCnt = 0; ended = 1'b0;
        for (int i = 0; i < 100 && !ended; i++) begin
            applyStimulus(1'b1);
            if (rx_valid) rxCnt++;
            if (!ss_n) begin
                lowCnt++;
                if (sclk) hiCnt++;
            end else if (lowCnt > 0) begin
                ended = 1'b1;
            end
        end
        checkOutput("frame ended", ended, 1);
        checkOutput("frame ss_n low ticks", lowCnt, 36);
        checkOutput("frame sclk high ticks", hiCnt, 16);
        gapCnt = 1;
        for (int i = 0; i < 20 && busy; i++) begin
            applyStimulus(1'b1);
            if (busy) gapCnt++;
        end
        checkOutput("frame gap ticks", gapCnt, 2);
        checkOutput("frame rx pulses", rxCnt, RX_EN ? 4 : 0);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1);
            if (!ss_n || busy) extra++;
        end
        checkOutput("no fifth word sent", extra, 0);
        checkOutput("ready after drain", din_ready, 1);

        $display("[TB] HOLD then closing word");
        pushWord(8'h3C, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) applyStimulus(1'b1);
        checkOutput("hold ss_n", ss_n, 0);
        checkOutput("hold sclk", sclk, 0);
        checkOutput("hold dout", dout, 0);
        checkOutput("hold dout_oe", dout_oe, 1);
        checkOutput("hold busy", busy, 1);
        pushWord(8'h55, 1'b1, 1'b1);
        hiCnt = 0; ended = 1'b0;
        for (int i = 0; i < 40 && !ended; i++) begin
            applyStimulus(1'b1);
            if (ss_n) ended = 1'b1;
            else if (sclk) hiCnt++;
        end
        checkOutput("hold close ended", ended, 1);
        checkOutput("hold close sclk ticks", hiCnt, 4);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1);
        checkOutput("hold close busy", busy, 0);
        checkOutput("hold close rx_data", rx_data, RX_EN ? 32'h55 : 32'h0);

        $display("[TB] 0xA7 across 1, 2 and 4 lanes");
        din = 8'hA7; din_last = 1'b1; din_valid = 1'b1; valid1 = 1'b1; valid4 = 1'b1;
        applyStimulus(1'b1);
        din_valid = 1'b0; valid1 = 1'b0; valid4 = 1'b0; din_last = 1'b0;
        e2 = 0; e1 = 0; e4 = 0; r2 = 0; r1 = 0; r4 = 0;
        d2 = '0; d1 = '0; d4 = '0;
        p2 = sclk; p1 = sclk1; p4 = sclk4;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1);
            if (sclk && !p2) e2++;
            if (sclk1 && !p1) e1++;
            if (sclk4 && !p4) e4++;
            p2 = sclk; p1 = sclk1; p4 = sclk4;
            if (rx_valid) begin r2++; d2 = rx_data; end
            if (rxValid1) begin r1++; d1 = rxData1; end
            if (rxValid4) begin r4++; d4 = rxData4; end
        end
        checkOutput("lanes2 sclk edges", e2, 4);
        checkOutput("lanes1 sclk edges", e1, 8);
        checkOutput("lanes4 sclk edges", e4, 2);
        checkOutput("lanes2 rx pulses", r2, RX_EN ? 1 : 0);
        checkOutput("lanes1 rx pulses", r1, RX_EN ? 1 : 0);
        checkOutput("lanes4 rx pulses", r4, RX_EN ? 1 : 0);
        checkOutput("lanes2 rx word", d2, RX_EN ? 32'hA7 : 32'h0);
        checkOutput("lanes1 rx word", d1, RX_EN ? 32'hA7 : 32'h0);
        checkOutput("lanes4 rx word", d4, RX_EN ? 32'hA7 : 32'h0);
        checkOutput("lanes1 idle", busy1, 0);
        checkOutput("lanes4 idle", busy4, 0);

        $display("[TB] reset during step 2");
        pushWord(8'h96, 1'b1, 1'b1);
        pushWord(8'h11, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        checkOutput("pre-reset in frame", ss_n, 0);
        rst_n = 1'b0;
        applyStimulus(1'b1);
        checkOutput("mid reset ss_n", ss_n, 1);
        checkOutput("mid reset dout_oe", dout_oe, 0);
        checkOutput("mid reset sclk", sclk, 0);
        checkOutput("mid reset dout", dout, 0);
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset din_ready", din_ready, 1);
        checkOutput("mid reset rx_valid", rx_valid, 0);
        checkOutput("mid reset rx_data", rx_data, 0);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1);
            if (rx_valid || !ss_n || busy) extra++;
        end
        checkOutput("post reset quiet", extra, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pocket_spi_shifter.md
Name: pocket_spi_shifter

Overview:
- Parametrised successor to the bench's Pocket bridge SPI byte shifter.
- Serialises queued command words over 1/2/4 data lanes with chip-select framing.
- Optionally deserialises returning lane data.
- Sits between the test harness command source and the bridge pins (brg_spiclk/brg_spimosi/brg_spimiso/brg_spiss); also usable in RTL.

Parameters:
- DW, 8: bits per word; must be a multiple of LANES.
- LANES, 2: data lanes per step; legal values 1, 2, 4.
- DEPTH, 4: transmit FIFO entries; power of 2, ≥2.
- GAP, 2: cen ticks ss_n stays high after a frame ends.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- cen  in  1  shift-rate enable; the FSM advances only when cen=1.
- din  in  DW  word to send.
- din_valid  in  1  push request.
- din_last  in  1  word ends a frame.
- din_ready  out  1  FIFO not full.
- sclk  out  1  serial clock; receiver samples on rising edge.
- ss_n  out  1  frame select, active low.
- dout  out  LANES  transmit lanes.
- dout_oe  out  1  lane/sclk drive enable, for tri-state at the top level.
- sin  in  LANES  receive lanes.
- rx_data  out  DW  last received word.
- rx_valid  out  1  one-cycle strobe.
- busy  out  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset values:
  - ss_n=1, sclk=0, dout=0, dout_oe=0.
  - rx_data=0, rx_valid=0, busy=0.
  - FIFO flushed; din_ready=1.
- FIFO:
  - Push when din_valid & din_ready; stores {din_last, din}.
  - din_ready = !full, combinational.
  - A push while full is ignored, even if a pop happens in the same cycle.
  - Push and pop are independent of cen.
- Bit order: LSB first. dout = sr[LANES-1:0]; sr shifts right by LANES per step. STEPS = DW/LANES.
- FSM states (transitions evaluated only on clk edges with cen=1):
  - IDLE: ss_n=1, dout_oe=0. Goes to LOAD if the FIFO is non-empty.
  - LOAD: pop word into sr, latch last flag, step cnt=STEPS-1, ss_n=0, dout_oe=1, sclk=0. Goes to LO.
  - LO: sclk=0, dout valid. Goes to HI.
  - HI: sclk=1; rx shift reg takes sin into its top LANES bits, shifting right.
    - cnt≠0: shift sr, cnt--, go to LO.
    - cnt=0, last=1: go to GAP.
    - cnt=0, last=0, FIFO non-empty: go to LOAD.
    - cnt=0, last=0, FIFO empty: go to HOLD.
  - HOLD: ss_n=0, sclk=0, dout held. Goes to LOAD when the FIFO is non-empty.
  - GAP: ss_n=1, dout_oe=0, gap counter runs GAP ticks, then IDLE. GAP=0 goes straight to IDLE.
- Timing:
  - Each step costs 2 cen ticks; a word costs 2·STEPS+1 ticks (including LOAD).
  - Back-to-back words within a frame have no extra gap beyond LOAD.
- rx_valid:
  - Pulses high for exactly one clk cycle, the cycle after the final HI tick of each word.
  - rx_data updates in that same cycle, with first-received lanes in the LSBs.
- A cen=0 stall at any point freezes all outputs.
- Reset mid-frame returns every output to its reset value on the next clk edge. A partial word is discarded and no rx_valid is produced.

Optional Feature:
- Macro: POCKET_SPI_RX_EN.
- Defined: receive shift register, rx_data and rx_valid behave as above.
- Undefined: rx logic is not built; rx_data=0 and rx_valid=0 constantly; sin is ignored.
- TX timing is identical in both builds.

Decomposition:
- Package pocket_spi_pkg holds:
  - FSM state encodings (IDLE, LOAD, LO, HI, HOLD, GAP);
  - the STEPS/counter-width functions (clog2);
  - the legal-LANES check constant.
- Sub-module pocket_spi_fifo: synchronous FIFO of width DW+1 and depth DEPTH, with full/empty and active-low synchronous reset.

Test Plan:
- DW=8, LANES=2, cen=1, push 0xB4 with last=1:
  - dout over the HI ticks = 00, 01, 11, 10.
  - ss_n low for 9 ticks, then high ≥ GAP ticks.
  - 4 sclk rising edges.
- Frame of F8,00,00,00 with last on the 4th word: ss_n stays low for all 16 HI ticks with no HOLD, then GAP=2 high ticks, then busy=0.
- DEPTH=4 with cen=0, push 5 words:
  - din_ready drops after the 4th push; the 5th is ignored.
  - With cen=1, exactly 4 words are transmitted.
- Push 0x3C with last=0 and nothing more: FSM sits in HOLD (ss_n=0, sclk=0). A later 0x55 with last=1 transmits, then the frame closes.
- POCKET_SPI_RX_EN, sin looped to dout, send 0xA7: rx_valid pulses once with rx_data=0xA7. LANES=1 and LANES=4 builds give the same result, with 8 and 2 sclk edges respectively.
- Assert rst_n=0 during step 2 of a word: the next edge gives ss_n=1, dout_oe=0, rx_valid never asserts, FIFO empty, din_ready=1.
